mydiv42: RTL and testbench

- Sequential restoring divider; the inverse of the team's 2x2 combinational multiplier.
- Takes a 4-bit dividend (the multiplier's product width) and a 2-bit divisor, and returns a 4-bit quotient and a 2-bit remainder after a fixed number of cycles.
- Used in the lab datapath to check a product against its factors (p / b == a, remainder 0).
- Start/done handshake with a busy indicator.

---
 rtl/mydiv42_pkg.sv | 17 +
 rtl/mydiv42_if.sv | 28 ++
 rtl/mydiv42_div_step.sv | 23 ++
 rtl/mydiv42.sv | 91 +++++++++
 tb/tb_mydiv42.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/mydiv42_pkg.sv
// rtl/mydiv42_pkg.sv - shared widths, FSM encoding and helpers for the restoring divider
package mydiv42_pkg;

  localparam int DW_DEF = 4;
  localparam int VW_DEF = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mydiv42_if.sv
// rtl/mydiv42_if.sv - start/done request and result bundle of the divider
interface mydiv42_if
  import mydiv42_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int VW = VW_DEF
);

  logic          start;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          busy;
  logic          done;
  logic          dbz;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, busy, done, dbz
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, busy, done, dbz
  );

endinterface

// File: rtl/mydiv42_div_step.sv
// rtl/mydiv42_div_step.sv - one restoring-division iteration, width-generic
module mydiv42_div_step
  import mydiv42_pkg::*;
#(
  parameter int VW = VW_DEF
) (
  input  logic [VW:0]   rem,
  input  logic          bit_in,
  input  logic [VW-1:0] divisor,
  output logic [VW:0]   rem_next,
  output logic          q_bit
);

  logic [VW:0] shifted;
  logic        unused_rem_msb;

  // Incoming remainder is always below the divisor, so its top bit is never set.
  assign unused_rem_msb = rem[VW];
  assign shifted        = {rem[VW-1:0], bit_in};
  assign q_bit          = (shifted >= {1'b0, divisor});
  assign rem_next       = q_bit ? (shifted - {1'b0, divisor}) : shifted;

endmodule

// File: rtl/mydiv42.sv
// rtl/mydiv42.sv - sequential restoring divider, DW-bit dividend by VW-bit divisor
module mydiv42
  import mydiv42_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int VW = VW_DEF
) (
  input  logic      clk,
  input  logic      rst_n,
  mydiv42_if.slave  bus
);

  localparam int CW = cnt_width(DW);

  state_t        state;
  logic [DW-1:0] shreg;
  logic [VW-1:0] dvsr;
  logic [VW:0]   prem;
  logic [CW-1:0] cnt;
  logic [VW:0]   prem_next;
  logic          qbit;

  mydiv42_div_step #(.VW(VW)) u_step (
    .rem      (prem),
    .bit_in   (shreg[DW-1]),
    .divisor  (dvsr),
    .rem_next (prem_next),
    .q_bit    (qbit)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      shreg         <= '0;
      dvsr          <= '0;
      prem          <= '0;
      cnt           <= '0;
      bus.quotient  <= '0;
      bus.remainder <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.dbz       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (bus.divisor != '0) begin
              shreg    <= bus.dividend;
              dvsr     <= bus.divisor;
              prem     <= '0;
              cnt      <= CW'(DW - 1);
              bus.busy <= 1'b1;
              state    <= CALC;
            end else begin
              bus.quotient  <= '1;
              bus.remainder <= '0;
              bus.dbz       <= 1'b1;
              bus.done      <= 1'b1;
              state         <= DONE;
            end
          end
        end
        CALC: begin
          // Dividend bits leave at the MSB while quotient bits enter at the LSB.
          prem  <= prem_next;
          shreg <= {shreg[DW-2:0], qbit};
          if (cnt == '0) begin
            bus.quotient  <= {shreg[DW-2:0], qbit};
            bus.remainder <= prem_next[VW-1:0];
            bus.dbz       <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b1;
            state         <= DONE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        DONE: begin
          bus.done <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mydiv42.sv
// tb/tb_mydiv42.sv - scoreboard bench for the restoring divider
module tb_mydiv42;
  import mydiv42_pkg::*;

  typedef struct {
    int q;
    int r;
    int dbz;
    int dd;
    int dv;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   done_cnt = 0;

  mydiv42_if bus ();

  mydiv42 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic push_exp(input int dd, input int dv);
    exp_t e;
    e.dd = dd;
    e.dv = dv;
    if (dv == 0) begin
      e.q   = (1 << DW_DEF) - 1;
      e.r   = 0;
      e.dbz = 1;
    end else begin
      e.q   = dd / dv;
      e.r   = dd % dv;
      e.dbz = 0;
    end
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = sb.pop_front();
        check("quotient", 32'(bus.quotient), e.q);
        check("remainder", 32'(bus.remainder), e.r);
        check("dbz", 32'(bus.dbz), e.dbz);
        check("busy_at_done", 32'(bus.busy), 0);
        if (e.dbz == 0)
          check("q*d+r", 32'(bus.quotient) * e.dv + 32'(bus.remainder), e.dd);
      end
    end
  end

  task automatic do_op(input int dd, input int dv);
    int busy_n;
    int cycles;
    @(posedge clk); #1;
    bus.start    = 1'b1;
    bus.dividend = 4'(dd);
    bus.divisor  = 2'(dv);
    push_exp(dd, dv);
    @(posedge clk); #1;
    bus.start = 1'b0;
    busy_n = 0;
    cycles = 0;
    while (!bus.done && cycles < 20) begin
      if (bus.busy) busy_n++;
      @(posedge clk); #1;
      cycles++;
    end
    check("latency", cycles, (dv == 0) ? 0 : DW_DEF);
    check("busy_cycles", busy_n, (dv == 0) ? 0 : DW_DEF);
    @(posedge clk); #1;
    check("done_one_cycle", 32'(bus.done), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int seen;
    int cycles;
    int stamps[3];

    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    rst_n        = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_quotient", 32'(bus.quotient), 0);
    check("rst_remainder", 32'(bus.remainder), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_dbz", 32'(bus.dbz), 0);
    rst_n = 1'b1;

    do_op(9, 3);

    for (int dd = 0; dd < 16; dd++)
      for (int dv = 1; dv < 4; dv++)
        do_op(dd, dv);

    do_op(5, 0);

    // A start issued mid-calculation must neither queue nor disturb the operands.
    @(posedge clk); #1;
    bus.start    = 1'b1;
    bus.dividend = 4'd6;
    bus.divisor  = 2'd2;
    push_exp(6, 2);
    d0 = done_cnt;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    bus.start    = 1'b1;
    bus.dividend = 4'd15;
    bus.divisor  = 2'd1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("single_done", done_cnt - d0, 1);

    @(posedge clk); #1;
    bus.start    = 1'b1;
    bus.dividend = 4'd9;
    bus.divisor  = 2'd2;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    d0 = done_cnt;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("abort_quotient", 32'(bus.quotient), 0);
    check("abort_remainder", 32'(bus.remainder), 0);
    check("abort_busy", 32'(bus.busy), 0);
    check("abort_done", 32'(bus.done), 0);
    check("abort_dbz", 32'(bus.dbz), 0);
    repeat (8) @(posedge clk);
    #1;
    check("no_done_after_abort", done_cnt - d0, 0);
    do_op(9, 2);

    @(posedge clk); #1;
    bus.start    = 1'b1;
    bus.dividend = 4'd12;
    bus.divisor  = 2'd3;
    for (int i = 0; i < 3; i++) push_exp(12, 3);
    seen = 0;
    cycles = 0;
    stamps = '{0, 0, 0};
    while (seen < 3 && cycles < 60) begin
      @(posedge clk); #1;
      cycles++;
      if (bus.done) begin
        stamps[seen] = cyc;
        seen++;
      end
    end
    bus.start = 1'b0;
    check("hold_pulses", seen, 3);
    check("hold_period1", stamps[1] - stamps[0], DW_DEF + 2);
    check("hold_period2", stamps[2] - stamps[1], DW_DEF + 2);

    repeat (4) @(posedge clk);
    #1;
    check("sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
